pipelined_adder: RTL
====================

// Module: pipelined_adder
// PURPOSE
//  Parametrised, pipelined ripple-carry adder/subtractor; successor to the fixed 4-bit combinational adder.
//  Splits a WIDTH-bit add into STAGES slices of WIDTH/STAGES bits, with one register stage per slice.
//  Slice carry-out feeds the next slice's carry-in through a register.
//  Valid/ready streaming interfaces on input and output; sits in datapaths needing wide adds at high clock rates.
// PARAMETERS
//  WIDTH   16  operand/result width in bits; must be a multiple of STAGES
//  STAGES  4   number of pipeline slices (1..WIDTH); latency in cycles
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      a/b/ci/sub are valid this cycle
//  in_ready   out  1      pipeline accepts input this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  ci         in   1      carry-in (add); borrow-in (sub)
//  sub        in   1      0: s=a+b+ci   1: s=a-b-ci
//  out_valid  out  1      s/co/ovf valid
//  out_ready  in   1      downstream accepts result
//  s          out  WIDTH  result, modulo 2^WIDTH
//  co         out  1      carry-out of MSB (sub: 1 = no borrow)
//  ovf        out  1      two's-complement signed overflow
// BEHAVIOUR
//  - Arithmetic: s,co = a + (b ^ {WIDTH{sub}}) + (ci ^ sub).
//    ovf = (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]).
//  - Slice k (k = 0..STAGES-1) adds bits [k*W+W-1 : k*W], where W = WIDTH/STAGES.
//    Its carry-in is the registered carry from slice k-1; slice 0 uses ci^sub.
//  - Skew: operand bits above slice k are delayed k cycles before reaching slice k.
//    Result bits below slice k ride along registered (deskew), so s leaves aligned.
//  - Latency: exactly STAGES cycles from accepted input to out_valid, with no stalls.
//  - Handshake: advance = !out_valid || out_ready; in_ready = advance (combinational).
//    Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
//  - When advance=1, every stage register shifts, including its valid bit.
//    A stage loaded with no input transfer becomes a bubble (valid=0).
//  - When advance=0 (full stall), all stages hold. Results are never dropped or duplicated.
//  - Throughput: one result per cycle while out_ready=1.
//    Bubbles collapse only at the output; a bubble at the output never blocks.
//  - While out_valid=1 && out_ready=0, s/co/ovf stay stable.
//  - Reset (async assert, any time, including mid-stream):
//    all stage valids=0; out_valid=0; s=0; co=0; ovf=0; all data/carry regs=0.
//    In-flight operations are discarded. in_ready=1 the cycle after reset deasserts.
//  - STAGES=1: single register after a full-width ripple; latency 1.
//  - Wrap-around: 0xFFFF+1 gives s=0, co=1; ovf set only on signed overflow.
// STRUCTURE
//  - Shared package (adder_pkg): ADD/SUB mode constants and the slice-width computation function.
//    Also an elaboration-time check that WIDTH % STAGES == 0.
//  - Sub-module adder_slice: W-bit combinational ripple of the team's 1-bit full adder
//    (ports bita, bitb, ci, co, s), generated per bit. It returns sum, carry-out, and the carry into its MSB (for ovf).
//  - Top: generate loop over STAGES instantiating adder_slice, plus skew/deskew and valid registers.
// TESTING (WIDTH=16, STAGES=4)
//  - Basic add: a=0x1234, b=0x0FF1, ci=0, sub=0 -> 4 cycles later out_valid=1, s=0x2225, co=0, ovf=0.
//  - Carry chain across all slices: a=0xFFFF, b=0x0000, ci=1 -> s=0x0000, co=1, ovf=0.
//    Signed overflow: a=0x7FFF, b=0x0001 -> s=0x8000, co=0, ovf=1.
//  - Subtract: a=0x0005, b=0x0007, sub=1, ci=0 -> s=0xFFFE, co=0 (borrow), ovf=0.
//    Same operands with ci=1 -> s=0xFFFD.
//  - Back-to-back stream of 8 random ops, out_ready=1 -> 8 consecutive results,
//    in order, matching the reference model.
//  - Backpressure: hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 once the output is valid.
//    s stays stable; on release all results arrive in order with none lost or duplicated.
//  - Reset mid-stream: assert rst with 3 ops in flight -> out_valid=0 and s=0 immediately.
//    None of the 3 ops appears after rst deasserts.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: operation modes and slice geometry helpers.
package adder_pkg;

  localparam logic ModeAdd = 1'b0;
  localparam logic ModeSub = 1'b1;

  function automatic int unsigned slice_width(int unsigned width, int unsigned stages);
    return width / stages;
  endfunction

  // Legal geometry: 1 <= stages <= width and stages divides width evenly.
  function automatic bit stages_ok(int unsigned width, int unsigned stages);
    if (stages < 1 || stages > width) return 1'b0;
    return (width % stages) == 0;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// W-bit combinational ripple-carry slice built from full_adder cells.
module adder_slice #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         cmsb
);

  logic c [W+1];

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .bita (a[i]),
      .bitb (b[i]),
      .ci   (c[i]),
      .co   (c[i+1]),
      .s    (s[i])
    );
  end

  assign co   = c[W];
  // Carry into the MSB; xor with co gives signed overflow.
  assign cmsb = c[W-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic bita,
  input  logic bitb,
  input  logic ci,
  output logic co,
  output logic s
);

  assign s  = bita ^ bitb ^ ci;
  assign co = (bita & bitb) | (ci & (bita ^ bitb));

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor with valid/ready streaming on both sides.
// One register stage per slice; operands are skewed in and sum bits deskewed out.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned W = slice_width(WIDTH, STAGES);

  if (!stages_ok(WIDTH, STAGES)) begin : g_param_check
    $error("pipelined_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin;

  logic             vld_q [STAGES];
  logic             cry_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic             ovf_q;

  logic [W-1:0]     sl_a  [STAGES];
  logic [W-1:0]     sl_b  [STAGES];
  logic [W-1:0]     sl_s  [STAGES];
  logic             sl_ci [STAGES];
  logic             sl_co [STAGES];
  logic             sl_cm [STAGES];

  assign b_eff = (sub == ModeAdd) ? b : ~b;
  assign cin   = ci ^ (sub == ModeSub);

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    if (k == 0) begin : g_first
      assign sl_a[k]  = a[W-1:0];
      assign sl_b[k]  = b_eff[W-1:0];
      assign sl_ci[k] = cin;
      assign s_d[k]   = WIDTH'(sl_s[k]);
    end else begin : g_rest
      assign sl_a[k]  = a_q[k-1][k*W +: W];
      assign sl_b[k]  = b_q[k-1][k*W +: W];
      assign sl_ci[k] = cry_q[k-1];
      // Bits above slice k-1 are still zero in s_q[k-1], so OR inserts this slice.
      assign s_d[k]   = s_q[k-1] | (WIDTH'(sl_s[k]) << (k*W));
    end

    adder_slice #(
      .W (W)
    ) u_slice (
      .a    (sl_a[k]),
      .b    (sl_b[k]),
      .ci   (sl_ci[k]),
      .s    (sl_s[k]),
      .co   (sl_co[k]),
      .cmsb (sl_cm[k])
    );
  end

  // Whole pipeline moves together; a full stall only happens with a result waiting.
  assign advance  = !vld_q[STAGES-1] || out_ready;
  assign in_ready = advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        cry_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      vld_q[0] <= in_valid;
      a_q[0]   <= a;
      b_q[0]   <= b_eff;
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        cry_q[k] <= sl_co[k];
        s_q[k]   <= s_d[k];
      end
      ovf_q <= sl_cm[STAGES-1] ^ sl_co[STAGES-1];
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign s         = s_q[STAGES-1];
  assign co        = cry_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule
